// File: rtl/acorn128_process_if.sv
// Handshake and data bundle for acorn128_process_core.
// The block drives busy/done and the result words; the requester drives the rest.
interface acorn128_process_if;
  logic         start_in;
  logic [292:0] state_in;
  logic [127:0] ad_in;
  logic [127:0] plaintext_in;
  logic [127:0] ciphertext_out;
  logic [127:0] tag_out;
  logic         busy_out;
  logic         done_out;

  modport master (
    output start_in, state_in, ad_in, plaintext_in,
    input  ciphertext_out, tag_out, busy_out, done_out
  );

  modport slave (
    input  start_in, state_in, ad_in, plaintext_in,
    output ciphertext_out, tag_out, busy_out, done_out
  );
endinterface

// File: rtl/acorn128_process_core.sv
// Bit-serial ACORN-128 back end: AD absorption, encryption, finalization; one step per clk.
// Optional macro ACORN_TRACE_EN adds simulation-only phase/tag printouts.
module acorn128_process_core (
  input  logic               clk,
  input  logic               rst,
  acorn128_process_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_AD, S_ENC, S_FINAL, S_DONE} fsm_t;

  fsm_t         cur, nxt;
  logic [10:0]  cnt;
  logic [292:0] st, st_nxt;
  logic [127:0] ad_sr, pt_sr, ct_acc, tag_acc, ct_q, tag_q;

  logic start_acc, step_en, last_step, finish;
  logic m_bit, ca, cb, ks;
  logic shift_ad, shift_pt, cap_tag;
  logic busy, done;
  logic in_word, pad_one, ca_win;

  assign in_word = (cnt < 11'd128);
  assign pad_one = (cnt == 11'd128);
  assign ca_win  = (cnt < 11'd256);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) cur <= S_IDLE;
    else      cur <= nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (bus.start_in)       nxt = S_AD;
      S_AD:    if (cnt == 11'd383)     nxt = S_ENC;
      S_ENC:   if (cnt == 11'd383)     nxt = S_FINAL;
      S_FINAL: if (cnt == 11'd767)     nxt = S_DONE;
      S_DONE:  if (bus.start_in)       nxt = S_AD;
      default:                         nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / step controls ----------------
  always_comb begin
    start_acc = 1'b0;
    step_en   = 1'b0;
    last_step = 1'b0;
    finish    = 1'b0;
    m_bit     = 1'b0;
    ca        = 1'b0;
    cb        = 1'b0;
    shift_ad  = 1'b0;
    shift_pt  = 1'b0;
    cap_tag   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (cur)
      S_IDLE: start_acc = bus.start_in;
      S_AD: begin
        step_en   = 1'b1;
        busy      = 1'b1;
        cb        = 1'b1;
        ca        = ca_win;
        shift_ad  = in_word;
        m_bit     = in_word ? ad_sr[0] : pad_one;
        last_step = (cnt == 11'd383);
      end
      S_ENC: begin
        step_en   = 1'b1;
        busy      = 1'b1;
        ca        = ca_win;
        shift_pt  = in_word;
        m_bit     = in_word ? pt_sr[0] : pad_one;
        last_step = (cnt == 11'd383);
      end
      S_FINAL: begin
        step_en   = 1'b1;
        busy      = 1'b1;
        ca        = 1'b1;
        cb        = 1'b1;
        cap_tag   = (cnt >= 11'd640);
        last_step = (cnt == 11'd767);
        finish    = last_step;
      end
      S_DONE: begin
        done      = 1'b1;
        start_acc = bus.start_in;
      end
      default: ;
    endcase
  end

  // ---------------- one state-update step ----------------
  // In-place feedback updates are order dependent: each line sees the results of the lines above.
  always_comb begin
    logic [292:0] t;
    logic         f;
    t = st;
    t[289] = t[289] ^ t[235] ^ t[230];
    t[230] = t[230] ^ t[196] ^ t[193];
    t[193] = t[193] ^ t[160] ^ t[154];
    t[154] = t[154] ^ t[111] ^ t[107];
    t[107] = t[107] ^ t[66]  ^ t[61];
    t[61]  = t[61]  ^ t[23]  ^ t[0];
    ks = t[12] ^ t[154]
       ^ ((t[235] & t[61]) ^ (t[235] & t[193]) ^ (t[61] & t[193]))
       ^ ((t[230] & t[111]) ^ (~t[230] & t[66]));
    f  = t[0] ^ ~t[107]
       ^ ((t[244] & t[23]) ^ (t[244] & t[160]) ^ (t[23] & t[160]))
       ^ (ca & t[196]) ^ (cb & ks) ^ m_bit;
    st_nxt = {f, t[292:1]};
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= '0;
      cnt     <= '0;
      ad_sr   <= '0;
      pt_sr   <= '0;
      ct_acc  <= '0;
      tag_acc <= '0;
      ct_q    <= '0;
      tag_q   <= '0;
    end else if (start_acc) begin
      st    <= bus.state_in;
      ad_sr <= bus.ad_in;
      pt_sr <= bus.plaintext_in;
      cnt   <= '0;
    end else if (step_en) begin
      st  <= st_nxt;
      cnt <= last_step ? 11'd0 : cnt + 11'd1;
      // Word inputs are consumed LSB first by shifting right once per absorbed bit.
      if (shift_ad) ad_sr <= {1'b0, ad_sr[127:1]};
      if (shift_pt) begin
        pt_sr  <= {1'b0, pt_sr[127:1]};
        ct_acc <= {pt_sr[0] ^ ks, ct_acc[127:1]};
      end
      if (cap_tag) tag_acc <= {ks, tag_acc[127:1]};
      // Published words move only at completion so they hold across the next run.
      if (finish) begin
        ct_q  <= ct_acc;
        tag_q <= {ks, tag_acc[127:1]};
      end
    end
  end

  assign bus.ciphertext_out = ct_q;
  assign bus.tag_out        = tag_q;
  assign bus.busy_out       = busy;
  assign bus.done_out       = done;

`ifdef ACORN_TRACE_EN
  int unsigned trace_cyc;
  always_ff @(posedge clk) begin
    if (!rst) trace_cyc <= 0;
    else      trace_cyc <= trace_cyc + 1;
    if (rst && (cur != nxt))
      $display("acorn128: enter %s at cycle %0d", nxt.name(), trace_cyc);
    if (rst && finish)
      $display("acorn128: tag %h", {ks, tag_acc[127:1]});
  end
`else
  // synthesis builds carry no trace logic
`endif

endmodule

// File: tb/tb_acorn128_process_core.sv
// Directed bench for acorn128_process_core: vector table checked against a behavioural ACORN model,
// plus reset-abort, ignored-start and back-to-back sequences.
module tb_acorn128_process_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acorn128_process_if bus ();

  acorn128_process_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [292:0] st;
    logic [127:0] ad;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] tag;
  } vec_t;

  vec_t         vecs [4];
  logic [127:0] got_ct  [4];
  logic [127:0] got_tag [4];
  int cmp_cnt = 0;
  int bad_cnt = 0;

  task automatic chk(input string nm, input logic [292:0] act, input logic [292:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_ne(input string nm, input logic [127:0] act, input logic [127:0] other);
    cmp_cnt++;
    if (act === other) begin
      bad_cnt++;
      $display("FAIL %s: got %h, required to differ from %h", nm, act, other);
    end
  endtask

  // Behavioural model of one ACORN step, written straight from the algorithm description.
  function automatic logic [292:0] mstep(input logic [292:0] s_in, input logic m,
                                         input logic ca, input logic cb, output logic ks);
    logic [292:0] s;
    logic         f, mj_k, ch_k, mj_f;
    s = s_in;
    s[289] ^= s[235] ^ s[230];
    s[230] ^= s[196] ^ s[193];
    s[193] ^= s[160] ^ s[154];
    s[154] ^= s[111] ^ s[107];
    s[107] ^= s[66] ^ s[61];
    s[61]  ^= s[23] ^ s[0];
    mj_k = (s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]);
    ch_k = s[230] ? s[111] : s[66];
    ks   = s[12] ^ s[154] ^ mj_k ^ ch_k;
    mj_f = (s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]);
    f    = s[0] ^ ~s[107] ^ mj_f ^ (ca & s[196]) ^ (cb & ks) ^ m;
    return {f, s[292:1]};
  endfunction

  task automatic model_run(input logic [292:0] s0, input logic [127:0] ad, input logic [127:0] pt,
                           output logic [127:0] ct, output logic [127:0] tag);
    logic [292:0] s;
    logic         ks, m;
    s = s0; ct = '0; tag = '0;
    for (int k = 0; k < 384; k++) begin
      m = (k < 128) ? ad[k] : (k == 128);
      s = mstep(s, m, (k < 256), 1'b1, ks);
    end
    for (int k = 0; k < 384; k++) begin
      m = (k < 128) ? pt[k] : (k == 128);
      s = mstep(s, m, (k < 256), 1'b0, ks);
      if (k < 128) ct[k] = pt[k] ^ ks;
    end
    for (int k = 0; k < 768; k++) begin
      s = mstep(s, 1'b0, 1'b1, 1'b1, ks);
      if (k >= 640) tag[k-640] = ks;
    end
  endtask

  // ACORN-128 initialisation with key=0, IV=0: only the step-256 key bit is inverted to 1.
  function automatic logic [292:0] init_zero_state();
    logic [292:0] s;
    logic         ks;
    s = '0;
    for (int i = 0; i < 1792; i++) s = mstep(s, (i == 256), 1'b1, 1'b1, ks);
    return s;
  endfunction

  task automatic drive_vec(input vec_t v);
    bus.state_in     = v.st;
    bus.ad_in        = v.ad;
    bus.plaintext_in = v.pt;
  endtask

  // Presents v with start high; returns 1 ns after the accepting edge.
  task automatic apply_start(input vec_t v);
    @(negedge clk);
    drive_vec(v);
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", {292'd0, bus.busy_out}, 293'd1);
  endtask

  // Counts edges after acceptance until done_out; optionally pulses start at cycle pulse_at.
  task automatic wait_done(input int pulse_at, output int n);
    n = 0;
    while (1) begin
      if (pulse_at >= 0 && n == pulse_at) begin
        bus.start_in = 1'b1;
        drive_vec(vecs[2]);
      end else if (pulse_at >= 0 && n == pulse_at + 1) begin
        bus.start_in = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (bus.done_out === 1'b1) break;
      if (n >= 2000) begin
        $display("FAIL done_timeout: no done_out within %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic scramble();
    bus.state_in     = ~bus.state_in;
    bus.ad_in        = ~bus.ad_in;
    bus.plaintext_in = ~bus.plaintext_in;
  endtask

  int lat;
  vec_t scr;

  initial begin
    bus.start_in = 1'b0;
    bus.state_in = '0;
    bus.ad_in = '0;
    bus.plaintext_in = '0;

    // ---- vector table ----
    vecs[0].st = init_zero_state();
    vecs[0].ad = '0;
    vecs[0].pt = '0;
    vecs[1] = vecs[0];
    vecs[1].pt[127] = 1'b1;
    vecs[2] = vecs[0];
    vecs[2].ad[0] = 1'b1;
    vecs[3].st = {37'h0A_5A5A_5A5A, 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe,
                  128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0};
    vecs[3].ad = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    vecs[3].pt = 128'hfedc_ba98_7654_3210_0123_4567_89ab_cdef;
    for (int i = 0; i < 4; i++)
      model_run(vecs[i].st, vecs[i].ad, vecs[i].pt, vecs[i].ct, vecs[i].tag);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ct",   {165'd0, bus.ciphertext_out}, 293'd0);
    chk("reset_tag",  {165'd0, bus.tag_out}, 293'd0);
    chk("reset_busy", {292'd0, bus.busy_out}, 293'd0);
    chk("reset_done", {292'd0, bus.done_out}, 293'd0);
    @(negedge clk) rst = 1'b1;

    // ---- table-driven runs ----
    for (int i = 0; i < 4; i++) begin
      apply_start(vecs[i]);
      bus.start_in = 1'b0;
      scramble();
      wait_done(-1, lat);
      chk($sformatf("v%0d_latency", i), 293'(lat), 293'd1536);
      chk($sformatf("v%0d_ct", i),  {165'd0, bus.ciphertext_out}, {165'd0, vecs[i].ct});
      chk($sformatf("v%0d_tag", i), {165'd0, bus.tag_out}, {165'd0, vecs[i].tag});
      chk($sformatf("v%0d_busy_at_done", i), {292'd0, bus.busy_out}, 293'd0);
      got_ct[i]  = bus.ciphertext_out;
      got_tag[i] = bus.tag_out;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_tag_hold", i), {165'd0, bus.tag_out}, {165'd0, vecs[i].tag});
    end

    // ---- causality and AD sensitivity against the golden expectation ----
    chk("pt127_ct_low_bits", {166'd0, got_ct[1][126:0]}, {166'd0, vecs[0].ct[126:0]});
    chk("pt127_ct_bit127",   {292'd0, got_ct[1][127]}, {292'd0, ~vecs[0].ct[127]});
    chk_ne("pt127_tag_differs", got_tag[1], vecs[0].tag);
    chk_ne("ad0_tag_differs",   got_tag[2], vecs[0].tag);
    chk_ne("ad0_ct_differs",    got_ct[2],  vecs[0].ct);

    // ---- reset during FINAL aborts the run ----
    apply_start(vecs[3]);
    bus.start_in = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_ct",   {165'd0, bus.ciphertext_out}, 293'd0);
    chk("abort_tag",  {165'd0, bus.tag_out}, 293'd0);
    chk("abort_busy", {292'd0, bus.busy_out}, 293'd0);
    chk("abort_done", {292'd0, bus.done_out}, 293'd0);
    @(negedge clk) rst = 1'b1;
    apply_start(vecs[0]);
    bus.start_in = 1'b0;
    wait_done(-1, lat);
    chk("post_abort_latency", 293'(lat), 293'd1536);
    chk("post_abort_tag", {165'd0, bus.tag_out}, {165'd0, vecs[0].tag});

    // ---- start pulse mid-run is ignored ----
    apply_start(vecs[0]);
    bus.start_in = 1'b0;
    wait_done(500, lat);
    chk("pulse_latency", 293'(lat), 293'd1536);
    chk("pulse_ct",  {165'd0, bus.ciphertext_out}, {165'd0, vecs[0].ct});
    chk("pulse_tag", {165'd0, bus.tag_out}, {165'd0, vecs[0].tag});

    // ---- start held high: back-to-back runs ----
    apply_start(vecs[0]);
    drive_vec(vecs[3]);
    wait_done(-1, lat);
    chk("b2b_first_latency", 293'(lat), 293'd1536);
    chk("b2b_first_tag", {165'd0, bus.tag_out}, {165'd0, vecs[0].tag});
    @(posedge clk); #1;
    chk("b2b_restart_done", {292'd0, bus.done_out}, 293'd0);
    chk("b2b_restart_busy", {292'd0, bus.busy_out}, 293'd1);
    bus.start_in = 1'b0;
    scr = vecs[1];
    drive_vec(scr);
    wait_done(-1, lat);
    chk("b2b_gap", 293'(lat + 1), 293'd1537);
    chk("b2b_second_ct",  {165'd0, bus.ciphertext_out}, {165'd0, vecs[3].ct});
    chk("b2b_second_tag", {165'd0, bus.tag_out}, {165'd0, vecs[3].tag});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end
endmodule
